// File: rtl/shift_left_iter.sv
// Iterative logical left shifter with selectable fill bit: one shift stage per cycle,
// valid/ready handshake on both sides, global stall freezes all state.
module shift_left_iter #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall_i,
    output logic             rdy_o,
    input  logic             val_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [DEPTH-1:0] b_i,
    input  logic             c_i,
    input  logic             rdy_i,
    output logic             val_o,
    output logic [WIDTH-1:0] d_o
);

    localparam int CNT_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SHIFT = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    logic [1:0]       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_work;
    logic [DEPTH-1:0] r_b;
    logic             r_c;

    logic             w_xfer_in;
    logic             w_xfer_out;
    logic             w_last;
    logic [WIDTH-1:0] w_stage;

    // Shift by 1<<j with vacated LSBs set to fill; shifts of WIDTH or more flood the word.
    function automatic logic [WIDTH-1:0] shift_fill(input logic [WIDTH-1:0] val,
                                                     input logic [CNT_W-1:0] j,
                                                     input logic             fill);
        int unsigned amt;
        amt = 32'd1 << j;
        if (amt >= WIDTH)
            return {WIDTH{fill}};
        return (val << amt) | ({WIDTH{fill}} & ~({WIDTH{1'b1}} << amt));
    endfunction

    assign rdy_o      = ((r_state == S_IDLE) | ((r_state == S_DONE) & rdy_i)) & ~stall_i;
    assign val_o      = (r_state == S_DONE) & ~stall_i;
    assign d_o        = r_work;
    assign w_xfer_in  = val_i & rdy_o;
    assign w_xfer_out = val_o & rdy_i;
    assign w_last     = (r_cnt == CNT_W'(DEPTH - 1));
    assign w_stage    = r_b[r_cnt] ? shift_fill(r_work, r_cnt, r_c) : r_work;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_work  <= '0;
            r_b     <= '0;
            r_c     <= 1'b0;
        end else if (!stall_i) begin
            // A transfer-in only happens from IDLE or from DONE with the result being taken.
            if (w_xfer_in) begin
                r_work  <= a_i;
                r_b     <= b_i;
                r_c     <= c_i;
                r_cnt   <= '0;
                r_state <= S_SHIFT;
            end else begin
                case (r_state)
                    S_SHIFT: begin
                        r_work <= w_stage;
                        if (w_last)
                            r_state <= S_DONE;
                        else
                            r_cnt <= r_cnt + CNT_W'(1);
                    end
                    S_DONE: begin
                        if (w_xfer_out)
                            r_state <= S_IDLE;
                    end
                    S_IDLE: ;
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

endmodule
